// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared widths, depths and the grant encoding of the SRAM-backed FIFO
package sram_fifo_pkg;
  localparam int DATA_W = 14;
  localparam int ADDR_W = 7;
  localparam int DEPTH = 2**ADDR_W;
  localparam int OBUF_DEPTH = 3;
  localparam int CNT_W = ADDR_W + 2;
  typedef enum logic [1:0] {G_IDLE, G_WR, G_RD} grant_e;
endpackage

// File: rtl/sram_fifo_obuf.sv
// sram_fifo_obuf: 3-entry prefetch queue (push/push_data in, out_valid/out_ready/out_data out, obuf_cnt occupancy)
module sram_fifo_obuf
  import sram_fifo_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        obuf_cnt
);
  logic [DATA_W-1:0] mem [OBUF_DEPTH];
  logic              pop;
  logic [1:0]        widx;
  assign out_valid = reset_n && obuf_cnt != 2'd0;
  assign pop = out_valid && out_ready;
  assign widx = obuf_cnt - 2'(pop);
  assign out_data = mem[0];
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      obuf_cnt <= '0;
    end else begin
      obuf_cnt <= obuf_cnt + 2'(push) - 2'(pop);
      if (pop) begin
        mem[0] <= mem[1];
        mem[1] <= mem[2];
      end
      if (push) mem[widx] <= push_data;
    end
  end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: ready/valid FIFO over a 128x14 single-port SRAM (in_*/out_* streams, sram_* macro pins, count occupancy)
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o,
  output logic [CNT_W-1:0]  count
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   sram_cnt;
  logic [1:0]        obuf_cnt;
  logic              rd_pend, rr, want_wr, want_rd, gw, gr;
  grant_e            grant;
  assign want_wr = in_valid && sram_cnt < (ADDR_W+1)'(DEPTH);
  // Prefetch budget ignores a same-cycle pop so the obuf can never overflow.
  assign want_rd = sram_cnt != '0 && 3'(obuf_cnt) + 3'(rd_pend) < 3'(OBUF_DEPTH);
  // rr records the last conflict winner; the other side takes the next conflict.
  always_comb begin
    grant = !reset_n ? G_IDLE :
            (want_wr && want_rd) ? (rr ? G_RD : G_WR) :
            want_wr ? G_WR :
            want_rd ? G_RD : G_IDLE;
  end
  assign gw = grant == G_WR;
  assign gr = grant == G_RD;
  assign sram_csb = !(gw || gr);
  assign sram_web = !gw;
  assign sram_oeb = !gr;
  assign sram_a = gr ? rd_ptr : wr_ptr;
  assign sram_i = in_data;
  assign in_ready = gw;
  assign count = CNT_W'(sram_cnt) + CNT_W'(rd_pend) + CNT_W'(obuf_cnt);
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      sram_cnt <= '0;
      rd_pend <= 1'b0;
      rr <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(gw);
      rd_ptr <= rd_ptr + ADDR_W'(gr);
      sram_cnt <= sram_cnt + (ADDR_W+1)'(gw) - (ADDR_W+1)'(gr);
      rd_pend <= gr;
      if (want_wr && want_rd) rr <= !rr;
    end
  end
  // The obuf reset also drops a read in flight, so its stale sram_o word is never captured.
  sram_fifo_obuf u_obuf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_pend),
    .push_data (sram_o),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .obuf_cnt  (obuf_cnt)
  );
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed bench for sram_fifo_ctrl with a behavioural 128x14 registered-output SRAM
module tb_sram_fifo_ctrl;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] out_data;
  logic [6:0]  sram_a;
  logic        sram_csb, sram_web, sram_oeb;
  logic [13:0] sram_i;
  logic [13:0] sram_o;
  logic [8:0]  count;
  logic [13:0] sram_mem [128];
  logic [13:0] q[$];
  logic        got_v;
  logic [13:0] got, exp;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = !clock;

  always @(posedge clock) begin
    if (!sram_csb && !sram_web) sram_mem[sram_a] <= sram_i;
    if (!sram_csb && !sram_oeb) sram_o <= sram_mem[sram_a];
  end

  sram_fifo_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sram_a    (sram_a),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_oeb  (sram_oeb),
    .sram_i    (sram_i),
    .sram_o    (sram_o),
    .count     (count)
  );

  task automatic drive(input logic iv, input logic [13:0] d, input logic ordy);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    logic ai, ao;
    logic [13:0] d, g;
    ai = in_valid && in_ready;
    ao = out_valid && out_ready;
    d = in_data;
    g = out_data;
    @(posedge clock);
    if (ai) q.push_back(d);
    got_v = ao;
    got = g;
    exp = 'x;
    if (ao && q.size() != 0) exp = q.pop_front();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 14'h155, 1'b1);
    checks++;
    if (sram_csb !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || sram_web !== 1'b1 || sram_oeb !== 1'b1) begin
      failures++;
      $display("FAIL reset_pins csb=%b web=%b oeb=%b in_ready=%b out_valid=%b want 1 1 1 0 0", sram_csb, sram_web, sram_oeb, in_ready, out_valid);
    end
    tick();
    tick();
    checks++;
    if (count !== 9'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", count);
    end
    reset_n = 1'b1;
    drive(1'b0, 14'h0, 1'b1);
    q.delete();
  endtask

  task automatic test_latency();
    drive(1'b1, 14'h0AB, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL lat_in_ready got=%b want=1", in_ready);
    end
    tick();
    for (int c = 1; c <= 2; c++) begin
      drive(1'b0, 14'h0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL lat_early cycle=%0d out_valid got=%b want=0", c, out_valid);
      end
      tick();
    end
    drive(1'b0, 14'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 14'h0AB) begin
      failures++;
      $display("FAIL lat_cycle3 out_valid=%b out_data=%h want 1 0ab", out_valid, out_data);
    end
    tick();
    checks++;
    if (!got_v || got !== exp) begin
      failures++;
      $display("FAIL lat_data got_v=%b got=%h want=%h", got_v, got, exp);
    end
    drive(1'b0, 14'h0, 1'b1);
    checks++;
    if (count !== 9'd0 || out_valid !== 1'b0 || sram_csb !== 1'b1) begin
      failures++;
      $display("FAIL lat_empty count=%0d out_valid=%b csb=%b want 0 0 1", count, out_valid, sram_csb);
    end
  endtask

  task automatic test_fill();
    int n = 0;
    int cyc = 0;
    while (n < 131 && cyc < 600) begin
      drive(1'b1, 14'(n), 1'b0);
      if (in_ready) n++;
      tick();
      cyc++;
    end
    checks++;
    if (n != 131) begin
      failures++;
      $display("FAIL fill_accepted got=%0d want=131", n);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 14'd131, 1'b0);
      tick();
    end
    drive(1'b1, 14'd131, 1'b0);
    checks++;
    if (count !== 9'd131 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full count=%0d in_ready=%b want 131 0", count, in_ready);
    end
  endtask

  task automatic test_full_block();
    drive(1'b1, 14'd131, 1'b1);
    checks++;
    if (in_ready !== 1'b0 || sram_csb !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_cycle in_ready=%b csb=%b want 0 1", in_ready, sram_csb);
    end
    tick();
    checks++;
    if (!got_v || got !== exp) begin
      failures++;
      $display("FAIL full_pop_data got_v=%b got=%h want=%h", got_v, got, exp);
    end
    drive(1'b1, 14'd131, 1'b0);
    checks++;
    if (sram_oeb !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_read_grant oeb=%b in_ready=%b want 0 0", sram_oeb, in_ready);
    end
    tick();
    drive(1'b1, 14'd131, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_reopen in_ready=%b want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_drain();
    int n = 0;
    int cyc = 0;
    while (q.size() != 0 && cyc < 400) begin
      drive(1'b0, 14'h0, 1'b1);
      tick();
      cyc++;
      if (got_v) begin
        n++;
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL drain_data idx=%0d got=%h want=%h", n, got, exp);
        end
      end
    end
    drive(1'b0, 14'h0, 1'b1);
    checks++;
    if (n != 131 || count !== 9'd0 || out_valid !== 1'b0 || sram_csb !== 1'b1) begin
      failures++;
      $display("FAIL drain_end words=%0d count=%0d out_valid=%b csb=%b want 131 0 0 1", n, count, out_valid, sram_csb);
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    int cyc = 0;
    int stall = 0;
    int max_stall = 0;
    int reads = 0;
    logic iv;
    while ((sent < 1000 || q.size() != 0) && cyc < 6000) begin
      iv = sent < 1000;
      drive(iv, 14'($urandom), 1'b1);
      if (!sram_oeb) reads++;
      if (iv && in_ready) begin
        sent++;
        stall = 0;
      end else if (iv) begin
        stall++;
        if (stall > max_stall) max_stall = stall;
      end
      tick();
      cyc++;
      if (got_v) begin
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL stream_data cyc=%0d got=%h want=%h", cyc, got, exp);
        end
      end
    end
    checks++;
    if (q.size() != 0 || sent != 1000 || reads != 1000) begin
      failures++;
      $display("FAIL stream_done sent=%0d reads=%0d left=%0d want 1000 1000 0", sent, reads, q.size());
    end
    checks++;
    if (max_stall > 1) begin
      failures++;
      $display("FAIL stream_wr_stall got=%0d want<=1", max_stall);
    end
  endtask

  task automatic test_reset_inflight();
    int n = 0;
    int cyc = 0;
    while (n < 6 && cyc < 50) begin
      drive(1'b1, 14'(14'h200 + n), 1'b0);
      if (in_ready) n++;
      tick();
      cyc++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 14'h0, 1'b0);
      tick();
    end
    drive(1'b0, 14'h0, 1'b1);
    tick();
    checks++;
    if (!got_v || got !== exp) begin
      failures++;
      $display("FAIL rip_pop got_v=%b got=%h want=%h", got_v, got, exp);
    end
    drive(1'b0, 14'h0, 1'b0);
    checks++;
    if (sram_oeb !== 1'b0) begin
      failures++;
      $display("FAIL rip_read_issue oeb=%b want 0", sram_oeb);
    end
    tick();
    reset_n = 1'b0;
    drive(1'b1, 14'h3FF, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || sram_csb !== 1'b1) begin
      failures++;
      $display("FAIL rip_in_reset in_ready=%b out_valid=%b csb=%b want 0 0 1", in_ready, out_valid, sram_csb);
    end
    tick();
    reset_n = 1'b1;
    q.delete();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 14'h0, 1'b1);
      checks++;
      if (count !== 9'd0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rip_after cycle=%0d count=%0d out_valid=%b want 0 0", i, count, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_toggle();
    int sent = 0;
    int cyc = 0;
    int got_n = 0;
    while ((sent < 200 || q.size() != 0) && cyc < 3000) begin
      drive(sent < 200, 14'(14'h1000 + sent * 7), cyc[0] == 1'b0);
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
      if (got_v) begin
        got_n++;
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL toggle_data idx=%0d got=%h want=%h", got_n, got, exp);
        end
      end
    end
    drive(1'b0, 14'h0, 1'b1);
    checks++;
    if (got_n != 200 || count !== 9'd0) begin
      failures++;
      $display("FAIL toggle_end words=%0d count=%0d want 200 0", got_n, count);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_latency();
    test_fill();
    test_full_block();
    test_drain();
    test_stream();
    test_reset_inflight();
    test_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
